// File: rtl/bullet_pkg.sv
// bullet_pkg: shared types and helpers for the player bullet pool.
//   aim_t        : 3-bit fire direction code (0=R 1=UR 2=U 3=UL 4=L 5=DL 6=D 7=DR)
//   coord_t      : signed working width for position arithmetic (no wrap on +/-SPEED)
//   aim_is_left  : true for the left-leaning codes (UL, L, DL)
//   aim_step     : decodes a direction into signed per-frame dx/dy
// Optional build macro: BULLET_AIM8_EN (all eight directions); without it
// bullets fly horizontally only, left for UL/L/DL and right otherwise.
package bullet_pkg;

    typedef enum logic [2:0] {
        AIM_R  = 3'd0,
        AIM_UR = 3'd1,
        AIM_U  = 3'd2,
        AIM_UL = 3'd3,
        AIM_L  = 3'd4,
        AIM_DL = 3'd5,
        AIM_D  = 3'd6,
        AIM_DR = 3'd7
    } aim_t;

    localparam int BULLET_SIZE  = 8;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int COORD_W      = 10;

    // Two spare bits above the 10-bit coordinate so x+dx can go negative or
    // past 1023 without wrapping before the bounds test.
    typedef logic signed [COORD_W+1:0] coord_t;

    function automatic logic aim_is_left(input aim_t a);
        return a inside {AIM_UL, AIM_L, AIM_DL};
    endfunction

    // y grows downward, so "up" is a negative dy.
    function automatic void aim_step(input aim_t a, input int speed,
                                     output coord_t dx, output coord_t dy);
        coord_t s;
        s = coord_t'(speed);
`ifdef BULLET_AIM8_EN
        case (a)
            AIM_R, AIM_UR, AIM_DR: dx = s;
            AIM_UL, AIM_L, AIM_DL: dx = -s;
            default:               dx = '0;
        endcase
        case (a)
            AIM_UR, AIM_U, AIM_UL: dy = -s;
            AIM_DL, AIM_D, AIM_DR: dy = s;
            default:               dy = '0;
        endcase
`else
        dx = aim_is_left(a) ? -s : s;
        dy = '0;
`endif
    endfunction

endpackage

// File: rtl/bullet_pool_ctrl_if.sv
// bullet_pool_ctrl_if: request/response bundle between the game logic and
// the bullet pool.
//   master (game logic / bench): drives fire, aim, spawn_x, spawn_y, hit_mask
//   slave  (bullet_pool_ctrl)  : drives bullet_status, bullet_x, bullet_y,
//                                active_count, fire_dropped
// Packing: slot i occupies bullet_x/bullet_y[10i+9:10i] and bullet_status[i].
interface bullet_pool_ctrl_if #(
    parameter int NUM_BULLETS = 10
);
    localparam int CNT_W = $clog2(NUM_BULLETS + 1);

    logic                       fire;
    logic [2:0]                 aim;
    logic [9:0]                 spawn_x;
    logic [9:0]                 spawn_y;
    logic [NUM_BULLETS-1:0]     hit_mask;

    logic [NUM_BULLETS-1:0]     bullet_status;
    logic [10*NUM_BULLETS-1:0]  bullet_x;
    logic [10*NUM_BULLETS-1:0]  bullet_y;
    logic [CNT_W-1:0]           active_count;
    logic                       fire_dropped;

    modport master (
        output fire, aim, spawn_x, spawn_y, hit_mask,
        input  bullet_status, bullet_x, bullet_y, active_count, fire_dropped
    );

    modport slave (
        input  fire, aim, spawn_x, spawn_y, hit_mask,
        output bullet_status, bullet_x, bullet_y, active_count, fire_dropped
    );

endinterface

// File: rtl/bullet_slot.sv
// bullet_slot: one entry of the bullet pool. Holds status, x, y and
// direction, and moves/retires itself on each frame tick.
// Ports:
//   Clk, Reset         : clock, synchronous active-high reset
//   tick               : one-cycle frame strobe
//   hit                : kill request for this slot
//   spawn              : load this slot with spawn_x/spawn_y/spawn_aim
//   status, pos_x/y    : registered slot state
//   status_nxt         : value status takes at the next edge (for popcount)
// Optional build macro: BULLET_AIM8_EN keeps the full 3-bit direction;
// otherwise only a left/right bit is stored.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int SPEED    = 4,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       hit,
    input  logic       spawn,
    input  aim_t       spawn_aim,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    output logic       status,
    output logic       status_nxt,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y
);

    localparam coord_t X_MAX = coord_t'(SCREEN_W - BULLET_SIZE);
    localparam coord_t Y_MAX = coord_t'(SCREEN_H - BULLET_SIZE);

    aim_t   dir_aim;
    coord_t step_dx;
    coord_t step_dy;
    coord_t nx;
    coord_t ny;
    logic   off_screen;
    logic   move;

`ifdef BULLET_AIM8_EN
    aim_t dir;
    assign dir_aim = dir;
`else
    logic dir_left;
    assign dir_aim = dir_left ? AIM_L : AIM_R;
`endif

    // Candidate position is formed in the wider signed type so the bounds
    // test sees the true value before anything is truncated back to 10 bits.
    always_comb begin
        aim_step(dir_aim, SPEED, step_dx, step_dy);
        nx = $signed({2'b00, pos_x}) + step_dx;
        ny = $signed({2'b00, pos_y}) + step_dy;
        off_screen = (nx < 0) || (nx > X_MAX) || (ny < 0) || (ny > Y_MAX);
    end

    // Spawn only ever targets a free slot, so it never competes with motion;
    // a hit beats motion on an active slot.
    always_comb begin
        status_nxt = status;
        move       = 1'b0;
        if (spawn) begin
            status_nxt = 1'b1;
        end else if (hit) begin
            status_nxt = 1'b0;
        end else if (tick && status) begin
            if (off_screen) begin
                status_nxt = 1'b0;
            end else begin
                move = 1'b1;
            end
        end
    end

    // Retired slots keep their last position; only status drops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            status <= 1'b0;
            pos_x  <= '0;
            pos_y  <= '0;
`ifdef BULLET_AIM8_EN
            dir    <= AIM_R;
`else
            dir_left <= 1'b0;
`endif
        end else begin
            status <= status_nxt;
            if (spawn) begin
                pos_x <= spawn_x;
                pos_y <= spawn_y;
`ifdef BULLET_AIM8_EN
                dir   <= spawn_aim;
`else
                dir_left <= aim_is_left(spawn_aim);
`endif
            end else if (move) begin
                pos_x <= nx[9:0];
                pos_y <= ny[9:0];
            end
        end
    end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: owns the player bullet pool. Spawns a bullet into the
// lowest free slot on a frame tick when fire is held and the cooldown has
// expired, advances every active bullet once per frame, and retires bullets
// that leave the screen or are hit.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   frame_clk  : vsync-derived level; its rising edge marks a frame
//   bus        : bullet_pool_ctrl_if.slave (fire/aim/spawn/hit in,
//                status/positions/count/fire_dropped out)
// Optional build macro: BULLET_AIM8_EN enables all eight fire directions.
module bullet_pool_ctrl
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 10,
    parameter int SPEED       = 4,
    parameter int COOLDOWN    = 8,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    bullet_pool_ctrl_if.slave     bus
);

    localparam int CNT_W = $clog2(NUM_BULLETS + 1);
    localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    logic                   frame_d;
    logic                   tick;
    logic [CD_W-1:0]        cooldown;
    logic [NUM_BULLETS-1:0] status;
    logic [NUM_BULLETS-1:0] status_nxt;
    logic [NUM_BULLETS-1:0] free_onehot;
    logic                   free_found;
    logic                   spawn_try;
    logic [NUM_BULLETS-1:0] spawn_vec;
    logic [CNT_W-1:0]       count_nxt;
    logic [CNT_W-1:0]       active_count;
    logic                   fire_dropped;
    aim_t                   spawn_aim;
    logic [9:0]             pos_x [NUM_BULLETS];
    logic [9:0]             pos_y [NUM_BULLETS];

    assign tick      = frame_clk & ~frame_d;
    assign spawn_aim = aim_t'(bus.aim);

    // Lowest-index free slot, judged on the registered status so a slot
    // freed this cycle is not reused until a later tick.
    always_comb begin
        free_onehot = '0;
        free_found  = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!free_found && !status[i]) begin
                free_onehot[i] = 1'b1;
                free_found     = 1'b1;
            end
        end
    end

    assign spawn_try = tick && (cooldown == '0) && bus.fire;
    assign spawn_vec = spawn_try ? free_onehot : '0;

    // Count of slots that will be active after this edge, so active_count
    // changes on the same edge as bullet_status.
    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            count_nxt = count_nxt + CNT_W'(status_nxt[i]);
        end
    end

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        bullet_slot #(
            .SPEED    (SPEED),
            .SCREEN_W (SCREEN_W),
            .SCREEN_H (SCREEN_H)
        ) u_slot (
            .Clk        (Clk),
            .Reset      (Reset),
            .tick       (tick),
            .hit        (bus.hit_mask[i]),
            .spawn      (spawn_vec[i]),
            .spawn_aim  (spawn_aim),
            .spawn_x    (bus.spawn_x),
            .spawn_y    (bus.spawn_y),
            .status     (status[i]),
            .status_nxt (status_nxt[i]),
            .pos_x      (pos_x[i]),
            .pos_y      (pos_y[i])
        );

        assign bus.bullet_x[10*i +: 10] = pos_x[i];
        assign bus.bullet_y[10*i +: 10] = pos_y[i];
    end

    // A refused spawn leaves cooldown at zero so the next tick retries.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_d      <= 1'b0;
            cooldown     <= '0;
            active_count <= '0;
            fire_dropped <= 1'b0;
        end else begin
            frame_d      <= frame_clk;
            active_count <= count_nxt;
            fire_dropped <= spawn_try && !free_found;
            if (tick) begin
                if (cooldown != '0) begin
                    cooldown <= cooldown - 1'b1;
                end else if (bus.fire && free_found) begin
                    cooldown <= CD_W'(COOLDOWN - 1);
                end
            end
        end
    end

    assign bus.bullet_status = status;
    assign bus.active_count  = active_count;
    assign bus.fire_dropped  = fire_dropped;

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// tb_bullet_pool_ctrl: directed scenarios plus a randomized run checked
// against a frame-level model of the bullet pool.
// Optional build macro: BULLET_AIM8_EN (changes expected diagonal motion).
module tb_bullet_pool_ctrl;

    localparam int NB       = 10;
    localparam int SPEED    = 4;
    localparam int COOLDOWN = 8;
    localparam int SCR_W    = 640;
    localparam int SCR_H    = 480;

    logic Clk;
    logic Reset;
    logic frame_clk;

    int tests_run;
    int tests_failed;

    bullet_pool_ctrl_if #(.NUM_BULLETS(NB)) bus ();

    bullet_pool_ctrl #(
        .NUM_BULLETS (NB),
        .SPEED       (SPEED),
        .COOLDOWN    (COOLDOWN),
        .SCREEN_W    (SCR_W),
        .SCREEN_H    (SCR_H)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state: one entry per slot.
    bit m_act [NB];
    int m_x   [NB];
    int m_y   [NB];
    int m_dx  [NB];
    int m_dy  [NB];
    int m_cd;
    bit m_fd;
    bit m_drop;

    function automatic int get_x(int i);
        return int'(bus.bullet_x[10*i +: 10]);
    endfunction

    function automatic int get_y(int i);
        return int'(bus.bullet_y[10*i +: 10]);
    endfunction

    // Direction table straight from the aim code list.
    task automatic aim_vec(input int a, output int dx, output int dy);
        int tdx [8];
        int tdy [8];
        tdx = '{1, 1, 0, -1, -1, -1, 0, 1};
        tdy = '{0, -1, -1, -1, 0, 1, 1, 1};
`ifdef BULLET_AIM8_EN
        dx = tdx[a] * SPEED;
        dy = tdy[a] * SPEED;
`else
        dx = (a >= 3 && a <= 5) ? -SPEED : SPEED;
        dy = 0;
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = SPEED; m_dy[i] = 0;
        end
        m_cd = 0; m_fd = 0; m_drop = 0;
    endtask

    // Advance the model by one Clk cycle using the currently driven inputs.
    task automatic model_step();
        bit tk;
        int fs;
        int nx;
        int ny;
        if (Reset) begin
            model_reset();
            return;
        end
        tk     = frame_clk && !m_fd;
        m_fd   = frame_clk;
        m_drop = 0;
        fs = -1;
        for (int i = 0; i < NB; i++) if (!m_act[i] && fs < 0) fs = i;
        for (int i = 0; i < NB; i++) begin
            if (bus.hit_mask[i]) begin
                m_act[i] = 0;
            end else if (tk && m_act[i]) begin
                nx = m_x[i] + m_dx[i];
                ny = m_y[i] + m_dy[i];
                if (nx < 0 || nx > SCR_W - 8 || ny < 0 || ny > SCR_H - 8) begin
                    m_act[i] = 0;
                end else begin
                    m_x[i] = nx;
                    m_y[i] = ny;
                end
            end
        end
        if (tk) begin
            if (m_cd > 0) begin
                m_cd--;
            end else if (bus.fire) begin
                if (fs >= 0) begin
                    m_act[fs] = 1;
                    m_x[fs]   = int'(bus.spawn_x);
                    m_y[fs]   = int'(bus.spawn_y);
                    aim_vec(int'(bus.aim), m_dx[fs], m_dy[fs]);
                    m_cd = COOLDOWN - 1;
                end else begin
                    m_drop = 1;
                end
            end
        end
    endtask

    task automatic clk_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic f, input int a, input int sx, input int sy);
        bus.fire    = f;
        bus.aim     = 3'(a);
        bus.spawn_x = 10'(sx);
        bus.spawn_y = 10'(sy);
    endtask

    task automatic do_reset();
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        bus.hit_mask = '0;
        applyStimulus(1'b0, 0, 0, 0);
        clk_cycle();
        clk_cycle();
        Reset = 1'b0;
    endtask

    // One frame pulse; dropped captures fire_dropped right after the tick edge.
    task automatic do_frame(output logic dropped);
        frame_clk = 1'b1;
        clk_cycle();
        dropped   = bus.fire_dropped;
        frame_clk = 1'b0;
        clk_cycle();
    endtask

    task automatic test_reset();
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        bus.hit_mask = '0;
        applyStimulus(1'b1, 0, 55, 66);
        clk_cycle();
        clk_cycle();
        tests_run++;
        if (bus.bullet_status !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_status got %h want 0", bus.bullet_status);
        end
        tests_run++;
        if (bus.active_count !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_count got %0d want 0", bus.active_count);
        end
        tests_run++;
        if (bus.fire_dropped !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_dropped got %b want 0", bus.fire_dropped);
        end
        tests_run++;
        if (bus.bullet_x !== '0 || bus.bullet_y !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_pos got x=%h y=%h want 0", bus.bullet_x, bus.bullet_y);
        end
        Reset = 1'b0;
    endtask

    task automatic test_spawn_motion();
        logic d;
        do_reset();
        applyStimulus(1'b1, 0, 100, 200);
        do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h001 || get_x(0) !== 100 || get_y(0) !== 200 || bus.active_count !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL first_spawn got st=%h x=%0d y=%0d cnt=%0d want 001 100 200 1",
                     bus.bullet_status, get_x(0), get_y(0), bus.active_count);
        end
        for (int f = 2; f <= 8; f++) begin
            do_frame(d);
            tests_run++;
            if (bus.bullet_status !== 10'h001 || get_x(0) !== 100 + SPEED * (f - 1)) begin
                tests_failed++;
                $display("[TB] FAIL cooldown_frame%0d got st=%h x0=%0d want 001 %0d",
                         f, bus.bullet_status, get_x(0), 100 + SPEED * (f - 1));
            end
        end
        do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h003 || get_x(1) !== 100 || get_x(0) !== 132) begin
            tests_failed++;
            $display("[TB] FAIL ninth_frame got st=%h x1=%0d x0=%0d want 003 100 132",
                     bus.bullet_status, get_x(1), get_x(0));
        end
        bus.fire = 1'b0;
    endtask

    task automatic test_boundary();
        logic d;
        do_reset();
        applyStimulus(1'b1, 0, 628, 100);
        do_frame(d);
        bus.fire = 1'b0;
        do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h001 || get_x(0) !== 632) begin
            tests_failed++; $display("[TB] FAIL right_edge_keep got st=%h x=%0d want 001 632", bus.bullet_status, get_x(0));
        end
        do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h000 || get_x(0) !== 632) begin
            tests_failed++; $display("[TB] FAIL right_edge_exit got st=%h x=%0d want 000 632", bus.bullet_status, get_x(0));
        end
        do_reset();
        applyStimulus(1'b1, 4, 2, 100);
        do_frame(d);
        bus.fire = 1'b0;
        tests_run++;
        if (bus.bullet_status !== 10'h001 || get_x(0) !== 2) begin
            tests_failed++; $display("[TB] FAIL left_spawn got st=%h x=%0d want 001 2", bus.bullet_status, get_x(0));
        end
        do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h000) begin
            tests_failed++; $display("[TB] FAIL left_edge_exit got st=%h want 000", bus.bullet_status);
        end
    endtask

    task automatic test_pool_full();
        logic d;
        do_reset();
        applyStimulus(1'b1, 0, 0, 100);
        for (int f = 1; f <= 80; f++) do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h3FF || bus.active_count !== 4'd10) begin
            tests_failed++; $display("[TB] FAIL pool_fill got st=%h cnt=%0d want 3ff 10", bus.bullet_status, bus.active_count);
        end
        for (int k = 0; k < 2; k++) begin
            do_frame(d);
            tests_run++;
            if (d !== 1'b1 || bus.active_count !== 4'd10) begin
                tests_failed++; $display("[TB] FAIL pool_full_drop%0d got drop=%b cnt=%0d want 1 10", k, d, bus.active_count);
            end
        end
        bus.spawn_x  = 10'd50;
        bus.hit_mask = 10'h008;
        clk_cycle();
        bus.hit_mask = '0;
        tests_run++;
        if (bus.bullet_status !== 10'h3F7 || bus.active_count !== 4'd9) begin
            tests_failed++; $display("[TB] FAIL hit_slot3 got st=%h cnt=%0d want 3f7 9", bus.bullet_status, bus.active_count);
        end
        do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h3FF || get_x(3) !== 50 || d !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL respawn_slot3 got st=%h x3=%0d drop=%b want 3ff 50 0", bus.bullet_status, get_x(3), d);
        end
    endtask

    // Runs straight after test_pool_full: pool full, cooldown just reloaded.
    task automatic test_hit_tick();
        logic d;
        for (int f = 0; f < COOLDOWN - 1; f++) do_frame(d);
        bus.hit_mask = 10'h001;
        frame_clk    = 1'b1;
        clk_cycle();
        d            = bus.fire_dropped;
        bus.hit_mask = '0;
        frame_clk    = 1'b0;
        tests_run++;
        if (bus.bullet_status !== 10'h3FE || d !== 1'b1 || bus.active_count !== 4'd9) begin
            tests_failed++;
            $display("[TB] FAIL hit_on_tick got st=%h drop=%b cnt=%0d want 3fe 1 9", bus.bullet_status, d, bus.active_count);
        end
        clk_cycle();
        do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h3FF || get_x(0) !== 50) begin
            tests_failed++; $display("[TB] FAIL retry_slot0 got st=%h x0=%0d want 3ff 50", bus.bullet_status, get_x(0));
        end
    endtask

    task automatic test_reset_mid();
        logic d;
        do_reset();
        applyStimulus(1'b1, 0, 10, 10);
        for (int f = 1; f <= 33; f++) do_frame(d);
        tests_run++;
        if (bus.bullet_status !== 10'h01F || bus.active_count !== 4'd5) begin
            tests_failed++; $display("[TB] FAIL five_active got st=%h cnt=%0d want 01f 5", bus.bullet_status, bus.active_count);
        end
        Reset     = 1'b1;
        frame_clk = 1'b1;
        clk_cycle();
        tests_run++;
        if (bus.bullet_status !== '0 || bus.active_count !== '0 || bus.bullet_x !== '0 ||
            bus.bullet_y !== '0 || bus.fire_dropped !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset got st=%h cnt=%0d drop=%b want all zero", bus.bullet_status, bus.active_count, bus.fire_dropped);
        end
        frame_clk = 1'b0;
        clk_cycle();
        Reset    = 1'b0;
        bus.fire = 1'b0;
        do_frame(d);
        tests_run++;
        if (bus.bullet_status !== '0 || bus.bullet_x !== '0) begin
            tests_failed++; $display("[TB] FAIL after_reset got st=%h x=%h want 0", bus.bullet_status, bus.bullet_x);
        end
    endtask

    task automatic test_aim();
        logic d;
        int   exp_y;
`ifdef BULLET_AIM8_EN
        exp_y = 296;
`else
        exp_y = 300;
`endif
        do_reset();
        applyStimulus(1'b1, 1, 300, 300);
        do_frame(d);
        bus.fire = 1'b0;
        do_frame(d);
        tests_run++;
        if (get_x(0) !== 304 || get_y(0) !== exp_y || bus.bullet_status !== 10'h001) begin
            tests_failed++;
            $display("[TB] FAIL aim_up_right got x=%0d y=%0d st=%h want 304 %0d 001", get_x(0), get_y(0), bus.bullet_status, exp_y);
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] exp_mask;
        int            exp_cnt;
        int            bad_slot;
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            Reset     = ($urandom_range(0, 199) == 0);
            frame_clk = ($urandom_range(0, 2) == 0);
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 660)), int'($urandom_range(0, 500)));
            bus.hit_mask = '0;
            if ($urandom_range(0, 7) == 0) bus.hit_mask[$urandom_range(0, NB - 1)] = 1'b1;
            model_step();
            clk_cycle();
            exp_cnt = 0;
            for (int i = 0; i < NB; i++) begin
                exp_mask[i] = m_act[i];
                exp_cnt += int'(m_act[i]);
            end
            tests_run++;
            if (bus.bullet_status !== exp_mask || int'(bus.active_count) !== exp_cnt) begin
                tests_failed++;
                $display("[TB] FAIL rand_status cyc %0d got st=%h cnt=%0d want %h %0d", c, bus.bullet_status, bus.active_count, exp_mask, exp_cnt);
            end
            tests_run++;
            if (bus.fire_dropped !== m_drop) begin
                tests_failed++; $display("[TB] FAIL rand_dropped cyc %0d got %b want %b", c, bus.fire_dropped, m_drop);
            end
            bad_slot = -1;
            for (int i = 0; i < NB; i++) begin
                if (bad_slot < 0 && (get_x(i) !== m_x[i] || get_y(i) !== m_y[i])) bad_slot = i;
            end
            tests_run++;
            if (bad_slot >= 0) begin
                tests_failed++;
                $display("[TB] FAIL rand_pos cyc %0d slot %0d got (%0d,%0d) want (%0d,%0d)", c, bad_slot,
                         get_x(bad_slot), get_y(bad_slot), m_x[bad_slot], m_y[bad_slot]);
            end
        end
        Reset     = 1'b0;
        frame_clk = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        bus.hit_mask = '0;
        applyStimulus(1'b0, 0, 0, 0);
        test_reset();
        test_spawn_motion();
        test_boundary();
        test_pool_full();
        test_hit_tick();
        test_reset_mid();
        test_aim();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
